trigger_chain_cfg_sequencer: RTL and testbench

//  Wishbone master that fans one configuration write out to any subset of the 8 trigger-chain channels.

---
 rtl/trigger_chain_cfg_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_trigger_chain_cfg_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_chain_cfg_sequencer.sv
// Wishbone write master that fans one configuration write out to a subset of the
// eight trigger-chain channels, lowest channel first, with per-channel retry/error/timeout.
module trigger_chain_cfg_sequencer #(
    parameter logic [21:0] BASE_ADR       = 22'h000000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_chmask_i,
    input  logic [7:0]  cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [21:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  err_chmask_o,
    input  logic        clear_err_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);

    function automatic logic [2:0] lowest_chan(input logic [7:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t      state_r, state_nx_s;
    logic [7:0]  pend_r, pend_nx_s;
    logic [3:0]  retry_r, retry_nx_s;
    logic [15:0] tmo_r, tmo_nx_s;
    logic [7:0]  adr_r, adr_nx_s;
    logic [31:0] dat_r, dat_nx_s;
    logic [2:0]  chan_s;
    logic        accept_s;
    logic        finish_s;
    logic        fail_s;
    logic [7:0]  fail_bits_s;
    logic        ready_r, busy_r, done_r, cyc_r;
    logic [21:0] wadr_r;
    logic [31:0] wdat_r;
    logic [7:0]  err_r;

    // The active channel is always the lowest still-pending one, so a retry
    // naturally stays on the same channel.
    assign chan_s      = lowest_chan(pend_r);
    assign accept_s    = cmd_valid_i && ready_r && (state_r == IDLE);
    assign adr_nx_s    = accept_s ? cmd_adr_i : adr_r;
    assign dat_nx_s    = accept_s ? cmd_dat_i : dat_r;
    assign fail_bits_s = fail_s ? (8'h01 << chan_s) : 8'h00;

    // Next-state, channel bookkeeping and response classification.
    always_comb begin
        state_nx_s = state_r;
        pend_nx_s  = pend_r;
        retry_nx_s = retry_r;
        tmo_nx_s   = tmo_r + 16'd1;
        finish_s   = 1'b0;
        fail_s     = 1'b0;
        case (state_r)
            IDLE: begin
                tmo_nx_s = 16'd0;
                if (accept_s) begin
                    pend_nx_s  = cmd_chmask_i;
                    retry_nx_s = 4'd0;
                    // An empty command still spends one cycle in GAP so its
                    // done pulse lines up with the per-channel cadence.
                    if (cmd_chmask_i != 8'h00) begin
                        state_nx_s = WRITE;
                    end else begin
                        state_nx_s = GAP;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WRITE: begin
                if (wbm_err_i) begin
                    finish_s = 1'b1;
                    fail_s   = 1'b1;
                end else if (wbm_ack_i) begin
                    finish_s = 1'b1;
                end else if (wbm_rty_i) begin
                    if (retry_r < RETRY_LIMIT) begin
                        retry_nx_s = retry_r + 4'd1;
                        state_nx_s = GAP;
                    end else begin
                        finish_s = 1'b1;
                        fail_s   = 1'b1;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    finish_s = 1'b1;
                    fail_s   = 1'b1;
                end else begin
                    state_nx_s = WRITE;
                end
            end
            GAP: begin
                tmo_nx_s = 16'd0;
                if (pend_r != 8'h00) begin
                    state_nx_s = WRITE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            DONE: begin
                tmo_nx_s   = 16'd0;
                state_nx_s = IDLE;
            end
            default: begin
                tmo_nx_s   = 16'd0;
                pend_nx_s  = 8'h00;
                state_nx_s = IDLE;
            end
        endcase
        if (finish_s) begin
            pend_nx_s  = pend_r & ~(8'h01 << chan_s);
            retry_nx_s = 4'd0;
            state_nx_s = GAP;
        end else begin
            pend_nx_s = pend_nx_s;
        end
    end

    // State, command latches and all registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
            pend_r  <= 8'h00;
            retry_r <= 4'd0;
            tmo_r   <= 16'd0;
            adr_r   <= 8'h00;
            dat_r   <= 32'd0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cyc_r   <= 1'b0;
            wadr_r  <= 22'd0;
            wdat_r  <= 32'd0;
            err_r   <= 8'h00;
        end else begin
            state_r <= state_nx_s;
            pend_r  <= pend_nx_s;
            retry_r <= retry_nx_s;
            tmo_r   <= tmo_nx_s;
            adr_r   <= adr_nx_s;
            dat_r   <= dat_nx_s;
            cyc_r   <= (state_nx_s == WRITE);
            if (state_nx_s == WRITE) begin
                wadr_r <= BASE_ADR | {11'd0, lowest_chan(pend_nx_s), adr_nx_s};
                wdat_r <= dat_nx_s;
            end else begin
                wadr_r <= 22'd0;
                wdat_r <= 32'd0;
            end
            done_r <= (state_r == DONE);
            if (accept_s) begin
                busy_r  <= 1'b1;
                ready_r <= 1'b0;
            end else if (done_r) begin
                busy_r  <= 1'b0;
                ready_r <= 1'b1;
            end else begin
                busy_r  <= busy_r;
                ready_r <= ready_r;
            end
            // A failure in the same cycle as a clear keeps its own bit.
            err_r <= (clear_err_i ? 8'h00 : err_r) | fail_bits_s;
        end
    end

    assign cmd_ready_o  = ready_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign wbm_cyc_o    = cyc_r;
    assign wbm_stb_o    = cyc_r;
    assign wbm_we_o     = cyc_r;
    assign wbm_sel_o    = {4{cyc_r}};
    assign wbm_adr_o    = wadr_r;
    assign wbm_dat_o    = wdat_r;
    assign err_chmask_o = err_r;

endmodule

// File: tb/tb_trigger_chain_cfg_sequencer.sv
// Bench for trigger_chain_cfg_sequencer: a scripted/random Wishbone responder
// plus a per-command reference model of writes, error mask and done latency.
module tb_trigger_chain_cfg_sequencer;

    localparam logic [21:0] BASE = 22'h15A800;
    localparam int TMO  = 16;
    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_chmask, cmd_adr;
    logic [31:0] cmd_dat;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic [21:0] wbm_adr;
    logic [31:0] wbm_dat;
    logic [3:0]  wbm_sel;
    logic        wbm_ack, wbm_err, wbm_rty;
    logic        busy, done, clear_err;
    logic [7:0]  err_chmask;

    always #5 clk = ~clk;

    trigger_chain_cfg_sequencer #(
        .BASE_ADR(BASE), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_chmask_i(cmd_chmask), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
        .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat), .wbm_sel_o(wbm_sel),
        .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .wbm_rty_i(wbm_rty),
        .busy_o(busy), .done_o(done), .err_chmask_o(err_chmask),
        .clear_err_i(clear_err)
    );

    // kind: 0 ack, 1 err, 2 rty, 3 no response
    typedef struct {
        int          kind;
        int          dly;
        bit          clr;
        int          len;
        logic [59:0] bus;
    } att_t;

    att_t       plan_q[$];
    att_t       force_q[$];
    att_t       cur;
    bit         in_att;
    int         att_cnt;
    bit         clr_req;
    logic [7:0] model_err;
    int         exp_cyc;
    int         test_cnt = 0;
    int         fail_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder: one scripted response per write attempt, checks bus and attempt length.
    task automatic slave_step();
        logic [59:0] bus;
        wbm_ack   = 1'b0;
        wbm_err   = 1'b0;
        wbm_rty   = 1'b0;
        clear_err = 1'b0;
        if (clr_req) begin
            clear_err = 1'b1;
            clr_req   = 1'b0;
        end
        bus = {wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat};
        if (wbm_cyc) begin
            if (!in_att) begin
                in_att  = 1'b1;
                att_cnt = 0;
                check_val("write_expected", 64'(plan_q.size() != 0), 64'd1);
                if (plan_q.size() != 0) cur = plan_q.pop_front();
                else cur = '{3, 0, 1'b0, -1, 60'd0};
            end else begin
                att_cnt++;
            end
            check_val("bus", 64'(bus), 64'(cur.bus));
            if (cur.kind != 3 && att_cnt == cur.dly) begin
                case (cur.kind)
                    0: wbm_ack = 1'b1;
                    1: wbm_err = 1'b1;
                    default: wbm_rty = 1'b1;
                endcase
                if (cur.clr) clear_err = 1'b1;
            end
        end else if (in_att) begin
            in_att = 1'b0;
            check_val("cyc_len", 64'(att_cnt + 1), 64'(cur.len));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        slave_step();
    endtask

    // Reference: walk channels in ascending order applying the response rules.
    task automatic build_model(input logic [7:0] mask, input logic [7:0] adr, input logic [31:0] dat);
        att_t a;
        int   cyc, tries, r;
        bit   fin, fail;
        cyc = 0;
        for (int ch = 0; ch < 8; ch++) begin
            if (mask[ch]) begin
                tries = 0;
                fin   = 1'b0;
                while (!fin) begin
                    if (force_q.size() != 0) begin
                        a = force_q.pop_front();
                    end else begin
                        r     = $urandom_range(0, 19);
                        a.kind = (r < 10) ? 0 : (r < 13) ? 1 : (r < 18) ? 2 : 3;
                        a.dly = $urandom_range(0, 3);
                        a.clr = 1'b0;
                    end
                    a.len = (a.kind == 3) ? TMO : a.dly + 1;
                    a.bus = {1'b1, 1'b1, 4'hF, 22'(BASE + ch * 256 + adr), dat};
                    cyc  += a.len + 1;
                    fail  = 1'b0;
                    case (a.kind)
                        0: fin = 1'b1;
                        2: begin
                            if (tries < MAXR) tries++;
                            else begin fin = 1'b1; fail = 1'b1; end
                        end
                        default: begin fin = 1'b1; fail = 1'b1; end
                    endcase
                    if (a.clr) model_err = 8'h00;
                    if (fail) model_err[ch] = 1'b1;
                    plan_q.push_back(a);
                end
            end
        end
        exp_cyc = (mask == 8'h00) ? 2 : cyc + 1;
    endtask

    task automatic issue_cmd(input logic [7:0] mask, input logic [7:0] adr, input logic [31:0] dat);
        int k;
        build_model(mask, adr, dat);
        k = 0;
        while (!cmd_ready && k < 100) begin tick(); k++; end
        check_val("ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_chmask = mask; cmd_adr = adr; cmd_dat = dat;
        tick();
        cmd_valid = 1'b0;
        check_val("busy_after_accept", 64'(busy), 64'd1);
        check_val("ready_after_accept", 64'(cmd_ready), 64'd0);
    endtask

    task automatic finish_cmd();
        int k;
        k = 0;
        while (!done && k < 3000) begin
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_chmask = 8'($urandom);
            cmd_adr    = 8'($urandom);
            tick();
            k++;
        end
        cmd_valid = 1'b0;
        check_val("done_latency", 64'(k), 64'(exp_cyc));
        check_val("err_chmask", 64'(err_chmask), 64'(model_err));
        check_val("plan_consumed", 64'(plan_q.size()), 64'd0);
        tick();
        check_val("busy_after_done", 64'(busy), 64'd0);
        check_val("ready_after_done", 64'(cmd_ready), 64'd1);
        check_val("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic run_cmd(input logic [7:0] mask, input logic [7:0] adr, input logic [31:0] dat);
        issue_cmd(mask, adr, dat);
        finish_cmd();
    endtask

    task automatic idle_clear();
        clr_req = 1'b1;
        tick();
        tick();
        model_err = 8'h00;
        check_val("clear_err", 64'(err_chmask), 64'd0);
    endtask

    initial begin
        logic any_cyc;
        logic [7:0] m;
        rst = 1'b1; cmd_valid = 1'b0; cmd_chmask = 8'h00; cmd_adr = 8'h00; cmd_dat = 32'd0;
        wbm_ack = 1'b0; wbm_err = 1'b0; wbm_rty = 1'b0; clear_err = 1'b0;
        clr_req = 1'b0; in_att = 1'b0; att_cnt = 0; model_err = 8'h00; exp_cyc = 0;
        repeat (3) tick();
        check_val("rst_ready", 64'(cmd_ready), 64'd1);
        check_val("rst_busy_done", 64'({busy, done}), 64'd0);
        check_val("rst_bus_ctl", 64'({wbm_cyc, wbm_stb, wbm_we, wbm_sel}), 64'd0);
        check_val("rst_bus_adr_dat", 64'({wbm_adr, wbm_dat}), 64'd0);
        check_val("rst_err", 64'(err_chmask), 64'd0);
        rst = 1'b0;
        tick();

        // all eight channels, ack in the first write cycle
        for (int i = 0; i < 8; i++) force_q.push_back('{0, 0, 1'b0, 0, 60'd0});
        run_cmd(8'hFF, 8'h12, 32'hDEADBEEF);
        check_val("t1_latency", 64'(exp_cyc), 64'd17);
        // empty mask
        run_cmd(8'h00, 8'h55, 32'h0);
        check_val("t2_err", 64'(err_chmask), 64'd0);
        // chan2 err, chan5 still written
        force_q.push_back('{1, 1, 1'b0, 0, 60'd0});
        force_q.push_back('{0, 2, 1'b0, 0, 60'd0});
        run_cmd(8'h24, 8'h12, 32'hCAFE0001);
        check_val("t3_err", 64'(err_chmask), 64'h04);
        idle_clear();
        // three retries then ack, then four retries
        for (int i = 0; i < 3; i++) force_q.push_back('{2, 0, 1'b0, 0, 60'd0});
        force_q.push_back('{0, 0, 1'b0, 0, 60'd0});
        run_cmd(8'h01, 8'h07, 32'h11112222);
        check_val("t4a_err", 64'(err_chmask), 64'h00);
        for (int i = 0; i < 4; i++) force_q.push_back('{2, 1, 1'b0, 0, 60'd0});
        run_cmd(8'h01, 8'h07, 32'h33334444);
        check_val("t4b_err", 64'(err_chmask), 64'h01);
        idle_clear();
        // timeout on chan3, chan4 proceeds
        force_q.push_back('{3, 0, 1'b0, 0, 60'd0});
        force_q.push_back('{0, 0, 1'b0, 0, 60'd0});
        run_cmd(8'h18, 8'hA0, 32'h0BADF00D);
        check_val("t5_err", 64'(err_chmask), 64'h08);
        // clear coinciding with a new err: only the new bit survives
        force_q.push_back('{1, 2, 1'b1, 0, 60'd0});
        run_cmd(8'h40, 8'h3C, 32'h5A5A5A5A);
        check_val("t6_clr_err", 64'(err_chmask), 64'h40);
        // reset in the middle of a write
        force_q.push_back('{3, 0, 1'b0, 0, 60'd0});
        issue_cmd(8'h01, 8'h33, 32'h12345678);
        repeat (5) tick();
        rst = 1'b1;
        plan_q.delete();
        in_att = 1'b0;
        tick();
        check_val("midrst_cyc_stb", 64'({wbm_cyc, wbm_stb}), 64'd0);
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_ready", 64'(cmd_ready), 64'd1);
        rst = 1'b0;
        model_err = 8'h00;
        any_cyc = 1'b0;
        repeat (4) begin tick(); any_cyc |= wbm_cyc; end
        check_val("midrst_no_write", 64'(any_cyc), 64'd0);
        run_cmd(8'h82, 8'h21, 32'h87654321);

        // randomized commands and responses
        for (int n = 0; n < 30; n++) begin
            m = 8'($urandom);
            if ($urandom_range(0, 7) == 0) m = 8'h00;
            run_cmd(m, 8'($urandom), $urandom);
            if ($urandom_range(0, 4) == 0) idle_clear();
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
